// File: rtl/pc_ctrl.sv
// Next-PC sequencer for the fetch stage: owns the PC register and arbitrates
// reset vector, sequential step, branch/trap redirect, stall and halt.
module pc_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int unsigned STEP      = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_br_taken,
  input  logic [31:0] i_br_target,
  input  logic        i_trap,
  input  logic [31:0] i_trap_vec,
  input  logic        i_halt,
  input  logic        i_ifu_ready,
  output logic [31:0] o_pc,
  output logic        o_pc_valid,
  output logic        o_misalign,
  output logic        o_halted
);

  // state | meaning
  // BOOT  | one idle cycle after reset release, no fetch
  // RUN   | fetching; redirects, stall and increment applied
  // HALT  | frozen after debug halt or misaligned branch; only a trap exits
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  localparam logic [31:0] STEP_W = 32'(STEP);

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        misalign, misalign_nxt;
  logic [31:0] trap_target;
  logic        fetch_acc;

  assign trap_target = i_trap_vec & ~32'h3;
  assign o_pc_valid  = (state == RUN) & ~i_stall;
  assign fetch_acc   = o_pc_valid & i_ifu_ready;
  assign o_halted    = (state == HALT);
  assign o_pc        = pc;
  assign o_misalign  = misalign;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= BOOT;
      pc       <= RESET_VEC;
      misalign <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      misalign <= misalign_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    misalign_nxt = misalign;
    case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        // Redirects win over stall and over an accepted fetch in the same cycle.
        if (i_trap) begin
          pc_nxt = trap_target;
        end else if (i_br_taken) begin
          pc_nxt = i_br_target;
          if (i_br_target[1:0] != 2'b00) begin
            misalign_nxt = 1'b1;
            state_nxt    = HALT;
          end
        end else if (i_halt) begin
          state_nxt = HALT;
        end else if (fetch_acc) begin
          pc_nxt = pc + STEP_W;
        end
      end
      HALT: begin
        if (i_trap) begin
          pc_nxt       = trap_target;
          misalign_nxt = 1'b0;
          state_nxt    = RUN;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: one instance at the default reset vector and a
// second one near the top of the address space to exercise wraparound.
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst, stall, br_taken, trap, halt, ifu_ready;
  logic [31:0] br_target, trap_vec;
  logic [31:0] pc_a, pc_b;
  logic        valid_a, valid_b, mis_a, mis_b, halted_a, halted_b;
  int          total = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  pc_ctrl dut_a (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_br_taken(br_taken),
    .i_br_target(br_target), .i_trap(trap), .i_trap_vec(trap_vec),
    .i_halt(halt), .i_ifu_ready(ifu_ready),
    .o_pc(pc_a), .o_pc_valid(valid_a), .o_misalign(mis_a), .o_halted(halted_a)
  );

  pc_ctrl #(.RESET_VEC(32'hFFFF_FFF8), .STEP(4)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_br_taken(br_taken),
    .i_br_target(br_target), .i_trap(trap), .i_trap_vec(trap_vec),
    .i_halt(halt), .i_ifu_ready(ifu_ready),
    .o_pc(pc_b), .o_pc_valid(valid_b), .o_misalign(mis_b), .o_halted(halted_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0;
    trap = 1'b0; trap_vec = '0; halt = 1'b0; ifu_ready = 1'b1;

    tick();
    check("rst_pc", pc_a, 32'h0);
    check("rst_valid", {31'b0, valid_a}, 32'd0);
    check("rst_mis", {31'b0, mis_a}, 32'd0);
    check("rst_halted", {31'b0, halted_a}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("boot_valid", {31'b0, valid_a}, 32'd0);
    check("boot_pc", pc_a, 32'h0);
    tick();
    check("run_pc0", pc_a, 32'h0);
    check("run_valid", {31'b0, valid_a}, 32'd1);
    tick();
    check("run_pc4", pc_a, 32'h4);
    tick();
    check("run_pc8", pc_a, 32'h8);
    tick();
    check("run_pc12", pc_a, 32'hC);
    tick();
    check("run_pc16", pc_a, 32'h10);

    // IFU back-pressure for three cycles
    ifu_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("nrdy_pc", pc_a, 32'h10);
      check("nrdy_valid", {31'b0, valid_a}, 32'd1);
    end
    ifu_ready = 1'b1;
    tick();
    check("rdy_pc", pc_a, 32'h14);
    tick(); tick(); tick();
    check("pc_20", pc_a, 32'h20);

    stall = 1'b1;
    #1;
    check("stall_valid", {31'b0, valid_a}, 32'd0);
    tick();
    check("stall_pc", pc_a, 32'h20);
    br_taken = 1'b1; br_target = 32'h100;
    tick();
    check("stall_br_pc", pc_a, 32'h100);
    br_taken = 1'b0; stall = 1'b0;
    #1;
    check("unstall_valid", {31'b0, valid_a}, 32'd1);

    // trap and branch together with an accepted fetch: trap wins, aligned
    trap = 1'b1; trap_vec = 32'h8000_0003; br_taken = 1'b1; br_target = 32'h200;
    tick();
    check("trap_pc", pc_a, 32'h8000_0000);
    trap = 1'b0; br_taken = 1'b0;
    tick();
    check("trap_inc", pc_a, 32'h8000_0004);

    br_taken = 1'b1; br_target = 32'h102;
    tick();
    br_taken = 1'b0;
    #1;
    check("mis_pc", pc_a, 32'h102);
    check("mis_flag", {31'b0, mis_a}, 32'd1);
    check("mis_halted", {31'b0, halted_a}, 32'd1);
    check("mis_valid", {31'b0, valid_a}, 32'd0);
    br_taken = 1'b1; br_target = 32'h300; halt = 1'b1;
    tick();
    br_taken = 1'b0; halt = 1'b0;
    check("halt_br_ign", pc_a, 32'h102);
    check("halt_stays", {31'b0, halted_a}, 32'd1);
    trap = 1'b1; trap_vec = 32'h40;
    tick();
    trap = 1'b0;
    #1;
    check("exit_pc", pc_a, 32'h40);
    check("exit_mis", {31'b0, mis_a}, 32'd0);
    check("exit_halted", {31'b0, halted_a}, 32'd0);
    check("exit_valid", {31'b0, valid_a}, 32'd1);

    halt = 1'b1;
    tick();
    halt = 1'b0;
    #1;
    check("dbg_halted", {31'b0, halted_a}, 32'd1);
    check("dbg_pc", pc_a, 32'h40);
    check("dbg_mis", {31'b0, mis_a}, 32'd0);

    // wraparound on the high reset vector instance
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("b_boot_pc", pc_b, 32'hFFFF_FFF8);
    check("b_boot_valid", {31'b0, valid_b}, 32'd0);
    tick();
    check("b_pc0", pc_b, 32'hFFFF_FFF8);
    check("b_valid", {31'b0, valid_b}, 32'd1);
    tick();
    check("b_pc1", pc_b, 32'hFFFF_FFFC);
    tick();
    check("b_wrap", pc_b, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("b_rst_pc", pc_b, 32'hFFFF_FFF8);
    check("b_rst_valid", {31'b0, valid_b}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Next-PC sequencer for the fetch stage; owns the architectural PC register and decides each cycle between reset vector, sequential increment, branch/jump redirect, trap redirect, stall and halt.
- Drives the instruction-fetch unit over a valid/ready handshake.
- Sits between the execute/trap logic (redirect sources) and the IFU (PC consumer).

Parameters:
- RESET_VEC, 32'h0000_0000, PC value loaded by reset; must be 4-byte aligned.
- STEP, 4, increment applied per accepted fetch.

Ports:
- i_clk  input  1  system clock, all state on rising edge
- i_rst  input  1  synchronous reset, active-high
- i_stall  input  1  pipeline stall; hold PC, suppress fetch
- i_br_taken  input  1  branch/jump redirect request
- i_br_target  input  32  redirect target address
- i_trap  input  1  trap/exception redirect request
- i_trap_vec  input  32  trap handler address
- i_halt  input  1  debug halt request
- i_ifu_ready  input  1  IFU can accept a fetch address
- o_pc  output  32  current fetch address (registered)
- o_pc_valid  output  1  o_pc is a valid fetch request
- o_misalign  output  1  sticky: redirect target had [1:0]!=0
- o_halted  output  1  controller in HALT state

Behaviour:
- Reset (i_rst=1 at an edge): o_pc=RESET_VEC, state=BOOT, o_misalign=0, o_halted=0, o_pc_valid=0. Reset overrides every other input.
- States: BOOT, RUN, HALT.
- BOOT: lasts exactly one cycle after reset release, then goes to RUN with o_pc unchanged. o_pc_valid=0 throughout.
- o_pc_valid is combinational: (state==RUN) & ~i_stall. A fetch is accepted when o_pc_valid & i_ifu_ready.
- RUN priority at each edge, highest first:
  1. i_trap: o_pc <= {i_trap_vec[31:2],2'b00}; stay in RUN.
  2. i_br_taken with i_br_target[1:0]==0: o_pc <= i_br_target.
  3. i_br_taken with i_br_target[1:0]!=0: o_pc <= i_br_target (kept for diagnosis), o_misalign <= 1, go to HALT.
  4. i_halt: go to HALT, o_pc held.
  5. i_stall: o_pc held.
  6. Fetch accepted: o_pc <= o_pc + STEP, modulo 2^32 (32'hFFFF_FFFC + 4 wraps to 0).
  7. Otherwise: hold. While the IFU is not ready, o_pc and o_pc_valid stay stable.
- Redirect (trap or branch) takes effect even when the current fetch is accepted in the same cycle. The redirect wins and no increment is applied.
- i_stall does not block redirects: trap or branch during stall still updates o_pc.
- HALT:
  - o_halted=1, o_pc_valid=0, o_pc held.
  - i_br_taken and i_halt are ignored.
  - Only i_trap exits: o_pc <= aligned i_trap_vec, o_misalign <= 0, go to RUN.
- o_halted = (state==HALT), combinational.
- Latency: a redirect at edge N is presented on o_pc in cycle N+1. After reset release, the first valid fetch of RESET_VEC is asserted 1 cycle later (BOOT).
- No X on outputs after reset; unused input values are don't-care.

Test Plan:
- Reset then free-run, i_ifu_ready=1, no stall. Required: o_pc_valid=0 during reset and BOOT, then o_pc=0,4,8,12 on consecutive cycles with valid=1.
- i_ifu_ready=0 for 3 cycles at o_pc=0x10. Required: o_pc stays 0x10 with valid=1; after ready rises, the next value is 0x14.
- i_stall=1 with ready=1 at o_pc=0x20. Required: valid=0, o_pc held at 0x20. Branch to 0x100 during the stall gives o_pc=0x100 next cycle.
- i_trap (vec 0x80000003) and i_br_taken (0x200) in the same cycle a fetch is accepted. Required: next o_pc=0x80000000.
- Branch to 0x102. Required: o_misalign=1, o_halted=1, valid=0, o_pc=0x102. A later branch is ignored; a trap to 0x40 gives RUN, o_pc=0x40, o_misalign=0.
- Start at RESET_VEC=0xFFFFFFF8 and free-run. Required: 0xFFFFFFF8, 0xFFFFFFFC, 0x0. Asserting i_rst mid-run returns o_pc to 0xFFFFFFF8 and valid=0 on the next cycle.
